// File: rtl/enc_4_to_2_sync.sv
// Registered 4-to-2 priority encoder (D > C > B > A) with valid and multi-hot flags.
// All four outputs update together on a rising edge when en=1; synchronous active-low reset.
module enc_4_to_2_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic A,
  input  logic B,
  input  logic C,
  input  logic D,
  output logic E0,
  output logic E1,
  output logic V,
  output logic ERR
);

  localparam int unsigned IDX_W = 2;

  logic [IDX_W-1:0] idx_c;
  logic             valid_c;
  logic             multi_c;

  // Priority index, any-request and two-or-more-request detection
  always_comb begin
    idx_c = IDX_W'(0);
    if (D)      idx_c = IDX_W'(3);
    else if (C) idx_c = IDX_W'(2);
    else if (B) idx_c = IDX_W'(1);
    else        idx_c = IDX_W'(0);
    valid_c = A | B | C | D;
    multi_c = (A & B) | (A & C) | (A & D) | (B & C) | (B & D) | (C & D);
  end

  // Output register; reset overrides enable
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      E1  <= 1'b0;
      E0  <= 1'b0;
      V   <= 1'b0;
      ERR <= 1'b0;
    end else if (en) begin
      E1  <= idx_c[1];
      E0  <= idx_c[0];
      V   <= valid_c;
      ERR <= multi_c;
    end
  end

endmodule

// File: tb/tb_enc_4_to_2_sync.sv
// Self-checking bench for enc_4_to_2_sync: directed plan plus randomized traffic
// compared against a loop-based reference of the priority/valid/popcount rules.
module tb_enc_4_to_2_sync;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [3:0] req;
  logic       E0, E1, V, ERR;

  int unsigned n_checks;
  int unsigned n_fail;

  logic [3:0] exp_out;   // {E1,E0,V,ERR}
  bit         exp_known;

  enc_4_to_2_sync dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .A     (req[0]),
    .B     (req[1]),
    .C     (req[2]),
    .D     (req[3]),
    .E0    (E0),
    .E1    (E1),
    .V     (V),
    .ERR   (ERR)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got E1E0/V/ERR=%b required %b at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: highest set request index, any-set flag, count of set requests >= 2
  function automatic logic [3:0] ref_enc(input logic [3:0] q);
    int hi = -1;
    int cnt = 0;
    for (int i = 0; i < 4; i++) begin
      if (q[i]) begin
        hi = i;
        cnt = cnt + 1;
      end
    end
    return {(hi < 0) ? 2'd0 : 2'(hi), (hi >= 0) ? 1'b1 : 1'b0, (cnt >= 2) ? 1'b1 : 1'b0};
  endfunction

  // Drive inputs just after an edge, confirm outputs hold until the next edge, then check the edge result
  task automatic cycle(input string tag, input logic r, input logic e, input logic [3:0] q);
    rst_n = r;
    en    = e;
    req   = q;
    #1;
    if (exp_known) check({tag, "_hold"}, {E1, E0, V, ERR}, exp_out);
    @(posedge clk);
    if (!r)     exp_out = 4'b0000;
    else if (e) exp_out = ref_enc(q);
    exp_known = 1'b1;
    #1;
    check(tag, {E1, E0, V, ERR}, exp_out);
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    exp_known = 1'b0;
    exp_out   = 4'b0000;
    rst_n     = 1'b0;
    en        = 1'bx;
    req       = 4'bxxxx;
    @(posedge clk);
    #1;

    // Reset with all requests high, then release
    cycle("rst0", 1'b0, 1'b1, 4'b1111);
    cycle("rst1", 1'b0, 1'b1, 4'b1111);
    cycle("rst_rel", 1'b1, 1'b1, 4'b1111);
    check("rst_rel_abs", {E1, E0, V, ERR}, 4'b1111);

    // Exhaustive sweep, A toggling fastest
    for (int k = 0; k < 16; k++) cycle($sformatf("sweep_%0d", k), 1'b1, 1'b1, 4'(k));

    // Latency: 0001 then 1000 right after the edge
    cycle("lat_a", 1'b1, 1'b1, 4'b0001);
    check("lat_a_abs", {E1, E0, V, ERR}, 4'b0010);
    cycle("lat_d", 1'b1, 1'b1, 4'b1000);
    check("lat_d_abs", {E1, E0, V, ERR}, 4'b1110);

    // Enable hold
    cycle("en_cap", 1'b1, 1'b1, 4'b0100);
    check("en_cap_abs", {E1, E0, V, ERR}, 4'b1010);
    for (int k = 0; k < 3; k++) cycle($sformatf("en_hold_%0d", k), 1'b1, 1'b0, 4'b0000);
    check("en_hold_abs", {E1, E0, V, ERR}, 4'b1010);
    cycle("en_resume", 1'b1, 1'b1, 4'b0000);
    check("en_resume_abs", {E1, E0, V, ERR}, 4'b0000);

    // Reset mid-operation
    cycle("mid_set", 1'b1, 1'b1, 4'b1000);
    cycle("mid_rst", 1'b0, 1'b1, 4'b1000);
    check("mid_rst_abs", {E1, E0, V, ERR}, 4'b0000);
    cycle("mid_rel", 1'b1, 1'b1, 4'b1000);
    check("mid_rel_abs", {E1, E0, V, ERR}, 4'b1110);

    // Reset pulse between edges must be ignored
    cycle("pulse_set", 1'b1, 1'b1, 4'b1010);
    #1 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    #1 check("pulse_between", {E1, E0, V, ERR}, exp_out);
    cycle("pulse_after", 1'b1, 1'b0, 4'b0000);
    check("pulse_after_abs", {E1, E0, V, ERR}, 4'b1111);

    // Randomized traffic with occasional reset and enable drops
    for (int k = 0; k < 300; k++) begin
      cycle("rand", ($urandom_range(0, 15) != 0) ? 1'b1 : 1'b0,
            ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0, 4'($urandom_range(0, 15)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/enc_4_to_2_sync.md
Name: enc_4_to_2_sync

Overview:
Registered 4-to-2 priority encoder. Four one-bit request lines A..D are encoded into a 2-bit index {E1,E0}. The block also produces a valid flag and a multi-hot flag. It sits in the datapath wherever a small set of request/select lines must be compressed into a binary index, with results aligned to the system clock.

Parameters:
none (fixed 4-input, 2-bit output function)

Ports:
clk   input   1  system clock; all state updates on rising edge
rst_n input   1  reset, synchronous, active-low
en    input   1  capture enable; 1 = update outputs this edge, 0 = hold
A     input   1  request 0 (lowest priority)
B     input   1  request 1
C     input   1  request 2
D     input   1  request 3 (highest priority)
E0    output  1  encoded index bit 0 (registered)
E1    output  1  encoded index bit 1 (registered)
V     output  1  valid: at least one request was high when captured (registered)
ERR   output  1  multi-hot: two or more requests were high when captured (registered)

Behaviour:
- One clock domain. Reset is synchronous, active-low.
- Reset is sampled only on the rising edge of clk. When rst_n=0 at an edge: E1=0, E0=0, V=0, ERR=0, regardless of en or inputs.
- Reset has priority over en. Deasserting rst_n mid-stream resumes normal capture on the first edge with rst_n=1 and en=1.
- Encoding is combinational priority logic, with highest set input winning, D > C > B > A:
  - D=1 -> {E1,E0}=11
  - else C=1 -> 10
  - else B=1 -> 01
  - else A=1 -> 00
  - none set -> 00
- V = A|B|C|D. It distinguishes "A only" (V=1) from "no request" (V=0); both give index 00.
- ERR = 1 when the popcount of {D,C,B,A} is >= 2. With ERR=1 the index is still the priority winner.
- All four outputs are registered together and change only on a rising edge with rst_n=1 and en=1.
- Latency: exactly 1 clock from input sample to output.
- en=0: all outputs hold their previous values and input changes are ignored.
- Inputs are sampled only at clock edges. Glitches between edges have no effect.
- Outputs never go X after reset, even if inputs were X before reset.
- No internal state beyond the four output flops.

Test Plan:
- Reset: hold rst_n=0 for 2 edges with A..D=1111 and en=1 -> E1E0=00, V=0, ERR=0. Release rst_n; next edge -> E1E0=11, V=1, ERR=1.
- Exhaustive sweep: en=1, apply all 16 combinations of {D,C,B,A} (A toggling fastest, D slowest, one per clock). Check one cycle later:
  - 0000 -> 00/V0/E0
  - 0001 -> 00/V1/E0
  - 0010 -> 01/V1/E0
  - 0011 -> 01/V1/ERR1
  - 0100 -> 10/V1/E0
  - 1000 -> 11/V1/E0
  - 1111 -> 11/V1/ERR1
  - remaining codes per the priority rule
- Latency: change inputs from 0001 to 1000 right after an edge -> outputs still 00 at that edge's result, 11 after the next edge.
- Enable hold: capture C only (E1E0=10, V=1). Drop en, change inputs to 0000 for 3 cycles -> outputs stay 10/V1/ERR0. Raise en -> next edge 00/V0/ERR0.
- Reset mid-operation: outputs at 11/V1. Assert rst_n=0 for one edge with en=1 and D=1 -> outputs 00/V0/ERR0 that edge, 11/V1 the following edge.
- Asynchronous-looking reset: pulse rst_n low between edges without it being low at any rising edge -> no output change.
